// File: rtl/expand_writer_pkg.sv
// Shared sizes, types and FSM encoding for the expand-layer output-map writer.
package expand_writer_pkg;

    localparam int WIDTH  = 16;
    localparam int DSP_NO = 64;
    localparam int BANKS  = 4;
    localparam int BEATS  = DSP_NO / BANKS;
    localparam int WOUT   = 64;
    localparam int PIXELS = WOUT * WOUT;
    localparam int ADDR_W = 16;
    localparam int BEAT_W = $clog2(BEATS);
    localparam int PIX_W  = $clog2(PIXELS);
    localparam int CH_W   = $clog2(DSP_NO);

    typedef logic [DSP_NO-1:0][WIDTH-1:0] vec_t;
    typedef logic [BANKS-1:0][WIDTH-1:0]  lane_t;

    typedef enum logic {
        S_IDLE,
        S_DRAIN
    } state_e;

    // BEATS is a power of two, so pixel*BEATS + beat is a plain concatenation.
    function automatic logic [ADDR_W-1:0] beat_addr(input logic [PIX_W-1:0]  pix,
                                                    input logic [BEAT_W-1:0] beat);
        return ADDR_W'({pix, beat});
    endfunction

endpackage

// File: rtl/expand_ofm_writer_if.sv
// Vector capture and bank-write bus between the expand layer, the writer and the OFM RAM.
interface expand_ofm_writer_if;
    import expand_writer_pkg::*;

    logic              sample_i;
    vec_t              ofm_i;
    logic              wr_en_o;
    logic [ADDR_W-1:0] wr_addr_o;
    lane_t             wr_data_o;
    logic              busy_o;
    logic              overrun_o;
    logic              done_o;

    modport master (
        input  sample_i, ofm_i,
        output wr_en_o, wr_addr_o, wr_data_o, busy_o, overrun_o, done_o
    );

    modport slave (
        output sample_i, ofm_i,
        input  wr_en_o, wr_addr_o, wr_data_o, busy_o, overrun_o, done_o
    );

endinterface

// File: rtl/ofm_vec_buffer.sv
// Two-slot ping-pong store for 64-channel vectors with write/read pointers and a 0..2 count.
module ofm_vec_buffer
    import expand_writer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  logic       pop_i,
    input  vec_t       vec_i,
    output logic       full_o,
    output logic       empty_o,
    output logic [1:0] count_o,
    output vec_t       rd_vec_o
);

    vec_t       slot_q [2];
    logic       wptr_q;
    logic       rptr_q;
    logic [1:0] cnt_q;
    logic       rptr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= 1'b0;
            rptr_q <= 1'b0;
            cnt_q  <= 2'd0;
        end else begin
            if (push_i) wptr_q <= ~wptr_q;
            if (pop_i)  rptr_q <= ~rptr_q;
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) slot_q[wptr_q] <= vec_i;
    end

    // Read view looks one edge ahead so the writer can register its lanes directly;
    // a vector landing in the slot about to be read is forwarded from the input.
    always_comb begin
        rptr_d   = pop_i ? ~rptr_q : rptr_q;
        rd_vec_o = (push_i && (wptr_q == rptr_d)) ? vec_i : slot_q[rptr_d];
    end

    assign full_o  = (cnt_q == 2'd2);
    assign empty_o = (cnt_q == 2'd0);
    assign count_o = cnt_q;

endmodule

// File: rtl/expand_ofm_writer.sv
// Drains buffered expand-layer vectors into a 4-bank OFM RAM, 4 channels per beat, and flags map completion.
module expand_ofm_writer
    import expand_writer_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    expand_ofm_writer_if.master ofm_if
);

    state_e              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [PIX_W-1:0]    pix_q, pix_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    lane_t               data_q, data_d;
    logic                wr_en_q;
    logic                busy_q;
    logic                ovr_q;
    logic                done_q;

    logic                pop;
    logic                push;
    logic                drop;
    logic                buf_full;
    logic                buf_empty;
    logic [1:0]          buf_count;
    vec_t                rd_vec;

    ofm_vec_buffer u_buf (
        .clk      (clk),
        .rst      (rst),
        .push_i   (push),
        .pop_i    (pop),
        .vec_i    (ofm_if.ofm_i),
        .full_o   (buf_full),
        .empty_o  (buf_empty),
        .count_o  (buf_count),
        .rd_vec_o (rd_vec)
    );

    always_comb begin
        pop  = !buf_empty && (beat_q == BEAT_W'(BEATS - 1));
        // A retiring slot frees room in the same edge, so a coincident sample is never lost.
        push = ofm_if.sample_i && (!buf_full || pop);
        drop = ofm_if.sample_i && buf_full && !pop;

        state_d = state_q;
        case (state_q)
            S_IDLE:  if (push) state_d = S_DRAIN;
            S_DRAIN: if (pop && (buf_count == 2'd1) && !push) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        beat_d = (state_q == S_DRAIN) ? beat_q + 1'b1 : '0;

        pix_d = pix_q;
        if (pop) pix_d = (pix_q == PIX_W'(PIXELS - 1)) ? '0 : pix_q + 1'b1;

        addr_d = '0;
        data_d = '0;
        if (state_d == S_DRAIN) begin
            addr_d = beat_addr(pix_d, beat_d);
            for (int b = 0; b < BANKS; b++) begin
                data_d[b] = rd_vec[CH_W'(int'(beat_d) * BANKS + b)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            pix_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wr_en_q <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            pix_q   <= pix_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wr_en_q <= (state_d == S_DRAIN);
            busy_q  <= (state_d == S_DRAIN);
            ovr_q   <= ovr_q | drop;
            done_q  <= pop && (pix_q == PIX_W'(PIXELS - 1));
        end
    end

    assign ofm_if.wr_en_o   = wr_en_q;
    assign ofm_if.wr_addr_o = addr_q;
    assign ofm_if.wr_data_o = data_q;
    assign ofm_if.busy_o    = busy_q;
    assign ofm_if.overrun_o = ovr_q;
    assign ofm_if.done_o    = done_q;

endmodule

// File: tb/tb_expand_ofm_writer.sv
// Randomised and directed bench for expand_ofm_writer against a queue-based model of the write stream.
module tb_expand_ofm_writer;
    import expand_writer_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    expand_ofm_writer_if bus();

    expand_ofm_writer dut (
        .clk    (clk),
        .rst    (rst),
        .ofm_if (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit armed  = 0;

    // Model: vectors still owed to the RAM; head is being written at beat m_pos.
    vec_t mq[$];
    int   m_pos = 0;
    int   m_pix = 0;
    bit   m_ovr = 0;
    bit   m_done = 0;

    vec_t stim_vec;
    bit   fixed_vec = 0;

    int   wr_count, first_wr, last_wr, done_cnt, done_cyc;
    logic [ADDR_W-1:0] last_addr;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h at cycle %0d", name, act, exp, cyc);
        end
    endfunction

    function automatic void clear_stats();
        wr_count  = 0;
        first_wr  = -1;
        last_wr   = -1;
        last_addr = '0;
        done_cnt  = 0;
        done_cyc  = -1;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        for (int c = 0; c < DSP_NO; c++) v[c] = WIDTH'($urandom);
        return v;
    endfunction

    function automatic void check_outputs();
        bit   en;
        vec_t h;
        if (!armed) return;
        en = (mq.size() != 0);
        h  = en ? mq[0] : '0;
        chk("wr_en", 64'(bus.wr_en_o), 64'(en));
        chk("wr_addr", 64'(bus.wr_addr_o), en ? 64'(m_pix * BEATS + m_pos) : 64'd0);
        for (int b = 0; b < BANKS; b++) begin
            chk($sformatf("wr_data[%0d]", b), 64'(bus.wr_data_o[b]),
                en ? 64'(h[CH_W'(m_pos * BANKS + b)]) : 64'd0);
        end
        chk("busy", 64'(bus.busy_o), 64'(en));
        chk("overrun", 64'(bus.overrun_o), 64'(m_ovr));
        chk("done", 64'(bus.done_o), 64'(m_done));
        if (bus.wr_en_o === 1'b1) begin
            wr_count++;
            if (first_wr < 0) first_wr = cyc;
            last_wr   = cyc;
            last_addr = bus.wr_addr_o;
        end
        if (bus.done_o === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    endfunction

    function automatic void model_step(input bit s, input bit r);
        bit had, retire;
        if (r) begin
            mq.delete();
            m_pos = 0; m_pix = 0; m_ovr = 0; m_done = 0;
            return;
        end
        had     = (mq.size() != 0);
        retire  = had && (m_pos == BEATS - 1);
        m_done  = 0;
        if (s) begin
            if (mq.size() < 2 || retire) mq.push_back(stim_vec);
            else m_ovr = 1;
        end
        if (retire) begin
            void'(mq.pop_front());
            m_pos  = 0;
            m_done = (m_pix == PIXELS - 1);
            m_pix  = (m_pix + 1) % PIXELS;
        end else if (had) begin
            m_pos++;
        end
    endfunction

    task automatic tick(input bit s, input bit r);
        check_outputs();
        if (s && !fixed_vec) stim_vec = rand_vec();
        rst          = r;
        bus.sample_i = s;
        bus.ofm_i    = stim_vec;
        model_step(s, r);
        @(negedge clk);
        cyc++;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_en"}, 64'(bus.wr_en_o), 64'd0);
        chk({tag, "_addr"}, 64'(bus.wr_addr_o), 64'd0);
        chk({tag, "_data"}, 64'(bus.wr_data_o), 64'd0);
        chk({tag, "_busy"}, 64'(bus.busy_o), 64'd0);
        chk({tag, "_ovr"}, 64'(bus.overrun_o), 64'd0);
        chk({tag, "_done"}, 64'(bus.done_o), 64'd0);
    endtask

    initial begin
        rst          = 1'b1;
        bus.sample_i = 1'b0;
        bus.ofm_i    = '0;
        stim_vec     = '0;
        clear_stats();
        @(negedge clk);
        tick(0, 1);
        armed = 1;
        check_all_zero("reset");

        // Single vector with channel-indexed data.
        clear_stats();
        for (int c = 0; c < DSP_NO; c++) stim_vec[c] = WIDTH'(16'h0100 + c);
        fixed_vec = 1;
        tick(1, 0);
        fixed_vec = 0;
        for (int k = 1; k <= 17; k++) begin
            if (k <= 16) begin
                chk("t1_en", 64'(bus.wr_en_o), 64'd1);
                chk("t1_addr", 64'(bus.wr_addr_o), 64'(k - 1));
                chk("t1_busy", 64'(bus.busy_o), 64'd1);
            end else begin
                chk("t1_busy_fall", 64'(bus.busy_o), 64'd0);
                chk("t1_en_fall", 64'(bus.wr_en_o), 64'd0);
            end
            if (k == 4) begin
                for (int b = 0; b < BANKS; b++)
                    chk("t1_beat3_lane", 64'(bus.wr_data_o[b]), 64'(16'h010C + b));
            end
            tick(0, 0);
        end

        // Full map at the layer's 17-cycle cadence.
        tick(0, 1);
        clear_stats();
        for (int i = 0; i < PIXELS; i++) begin
            tick(1, 0);
            repeat (16) tick(0, 0);
        end
        repeat (5) tick(0, 0);
        chk("cad_writes", 64'(wr_count), 64'd65536);
        chk("cad_last_addr", 64'(last_addr), 64'hFFFF);
        chk("cad_done_cnt", 64'(done_cnt), 64'd1);
        chk("cad_done_cyc", 64'(done_cyc), 64'(last_wr + 1));
        chk("cad_overrun", 64'(bus.overrun_o), 64'd0);
        tick(1, 0);
        chk("wrap_en", 64'(bus.wr_en_o), 64'd1);
        chk("wrap_addr", 64'(bus.wr_addr_o), 64'd0);
        repeat (17) tick(0, 0);

        // Back-to-back samples; the third overruns.
        tick(0, 1);
        clear_stats();
        tick(1, 0); tick(1, 0); tick(1, 0);
        repeat (40) tick(0, 0);
        chk("b2b_writes", 64'(wr_count), 64'd32);
        chk("b2b_span", 64'(last_wr - first_wr + 1), 64'd32);
        chk("b2b_last_addr", 64'(last_addr), 64'd31);
        chk("b2b_overrun", 64'(bus.overrun_o), 64'd1);

        // Sample coincident with beat 15 while two vectors are held.
        tick(0, 1);
        clear_stats();
        tick(1, 0); tick(1, 0);
        repeat (14) tick(0, 0);
        chk("co_beat15_addr", 64'(bus.wr_addr_o), 64'd15);
        tick(1, 0);
        repeat (50) tick(0, 0);
        chk("co_writes", 64'(wr_count), 64'd48);
        chk("co_span", 64'(last_wr - first_wr + 1), 64'd48);
        chk("co_last_addr", 64'(last_addr), 64'd47);
        chk("co_overrun", 64'(bus.overrun_o), 64'd0);

        // Reset during beat 7 of pixel 5.
        tick(0, 1);
        clear_stats();
        for (int k = 0; k < 5; k++) begin
            tick(1, 0);
            repeat (16) tick(0, 0);
        end
        tick(1, 0);
        repeat (7) tick(0, 0);
        chk("rstpt_en", 64'(bus.wr_en_o), 64'd1);
        chk("rstpt_addr", 64'(bus.wr_addr_o), 64'd87);
        tick(0, 1);
        clear_stats();
        for (int k = 0; k < 10; k++) begin
            check_all_zero("post_rst");
            tick(0, 0);
        end
        chk("post_rst_writes", 64'(wr_count), 64'd0);
        tick(1, 0);
        chk("fresh_en", 64'(bus.wr_en_o), 64'd1);
        chk("fresh_addr", 64'(bus.wr_addr_o), 64'd0);
        repeat (17) tick(0, 0);

        // Random traffic with varying density and occasional resets.
        tick(0, 1);
        for (int blk = 0; blk < 15; blk++) begin
            int dens;
            dens = int'($urandom_range(2, 20));
            for (int i = 0; i < 200; i++) begin
                bit s, r;
                s = ($urandom_range(0, dens - 1) == 0);
                r = ($urandom_range(0, 799) == 0);
                tick(s, r);
            end
        end
        repeat (40) tick(0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/expand_ofm_writer.md
# expand_ofm_writer

Drains the 64-channel output vectors of the fire2/fire3 expand 1×1 layer into a 4-bank output feature-map RAM. It captures the parallel `ofm_i` vector on each `sample_i` pulse, buffers up to two vectors in a ping-pong store, and writes each one as 16 beats of 4 channels. After the last pixel of a 64×64 map it pulses `done_o`, which drives the layer's `ram_feedback` input, then re-arms for the next layer.

## Interface
- `WIDTH`, 16, data word width
- `DSP_NO`, 64, channels per output vector
- `BANKS`, 4, RAM banks written in parallel
- `WOUT`, 64, output map width and height; pixels per map = `WOUT`²
- `ADDR_W`, 16, bank address width; must be at least log2(`WOUT`² × `DSP_NO`/`BANKS`)

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `sample_i`  in  1  one-cycle pulse; `ofm_i` valid this cycle
- `ofm_i`  in  `WIDTH` × [0:`DSP_NO`-1]  output vector from the expand layer
- `wr_en_o`  out  1  bank write strobe, common to all banks
- `wr_addr_o`  out  `ADDR_W`  bank address, common to all banks
- `wr_data_o`  out  `WIDTH` × [0:`BANKS`-1]  lane b holds channel 4·beat+b
- `busy_o`  out  1  at least one vector is buffered or draining
- `overrun_o`  out  1  sticky flag: a vector was dropped
- `done_o`  out  1  one-cycle pulse after the final write of the map

## Operation
- Ping-pong store: two vector slots, with write pointer, read pointer and count (0..2).
- On `sample_i`, `ofm_i` is copied into the slot at the write pointer.
- Drain: while count > 0, one beat is issued per cycle from the slot at the read pointer. `beat` runs 0..15.
  - `wr_data_o[b]` = slot[4·beat+b].
  - `wr_addr_o` = pixel·16 + beat.
- On beat 15 the read pointer toggles, count decrements and the pixel counter increments.
- Simultaneous `sample_i` and beat-15 retire:
  - The new vector is always accepted, even when count = 2.
  - Count is unchanged.
- `sample_i` when count = 2 and no retire that cycle:
  - The vector is dropped.
  - `overrun_o` is set and stays high until `rst`.
  - Pointers, count and the pixel counter are unaffected.
- Pixel counter runs 0..`WOUT`²-1.
  - On the retire of pixel `WOUT`²-1, `done_o` pulses in the following cycle.
  - The pixel counter wraps to 0, so fire3 reuses the block without reset.
- Data passes through unmodified; quantisation and ReLU belong to the layer.
- FSM states:
  - IDLE (count = 0) → DRAIN on `sample_i`.
  - DRAIN → IDLE when beat 15 retires with count = 1 and no `sample_i`.
  - DRAIN otherwise stays in DRAIN.

## Timing
- Reset values: `wr_en_o`=0, `wr_addr_o`=0, `wr_data_o`=0, `busy_o`=0, `overrun_o`=0, `done_o`=0.
- Reset also clears pointers, count, beat counter and pixel counter.
- `rst` mid-drain aborts all buffered vectors. No write occurs in the cycle after `rst`.
- Latency: `sample_i` in cycle t → `wr_en_o` high in cycles t+1..t+16, with beat 0 at t+1. All outputs are registered.
- Throughput: one vector per 16 cycles with no bubble when count stays ≥ 1. The layer's 17-cycle cadence therefore never overruns.
- `busy_o` = (count > 0), registered: it rises at t+1 and falls the cycle after the final beat.
- `done_o` is high in the cycle after the final `wr_en_o` beat of the map. It coincides with the `busy_o` fall when nothing else is pending.

## Structure
- Package `expand_writer_pkg`: `WIDTH`, `DSP_NO`, `BANKS`, `BEATS` = `DSP_NO`/`BANKS`, `PIXELS` = `WOUT`², the `vec_t` array typedef, and the FSM state enum.
- Sub-module `ofm_vec_buffer`: two-slot ping-pong store with pointers and count. It exposes push, pop, full, empty and the read slot.
- The top level holds the FSM, beat and pixel counters, address generation and flags.

## Test plan
- Single vector, ofm_i[c] = 16'h0100 + c: `sample_i` at t=10 → writes at cycles 11..26. Addresses 0..15; beat 3 lanes = 16'h010C..16'h010F; `busy_o` falls at 27.
- Layer cadence: 4096 samples at a 17-cycle spacing → 65536 writes, last address 16'hFFFF. `done_o` is a single pulse one cycle after the last write; `overrun_o` stays 0; the pixel counter returns to 0.
- Back-to-back samples at t and t+1 → 32 contiguous write cycles, addresses 0..31, no bubble; a third sample at t+2 sets `overrun_o` and is never written.
- Sample coincident with beat 15 while count = 2 → the vector is accepted, `overrun_o` stays 0 and all three vectors are written in order.
- `rst` asserted during beat 7 of pixel 5 → no `wr_en_o` afterward and all outputs read 0. A fresh sample then writes starting at address 0.
